// File: rtl/cronometro_pkg.sv
// cronometro_pkg: shared digit types, digit limits and active-low A..G segment patterns
package cronometro_pkg;
    typedef logic [3:0] unit_t;
    typedef logic [2:0] tens_t;
    localparam unit_t UNIT_MAX = 4'd9;
    localparam tens_t TENS_MAX = 3'd5;
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
endpackage

// File: rtl/seg7_dec.sv
// seg7_dec: 4-bit digit to active-low {A..G} pattern, codes above 9 blank
module seg7_dec
    import cronometro_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);
    always_comb begin
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/contador_regressivo_seg.sv
// contador_regressivo_seg: two-digit 59..00 seconds countdown with preset load, borrow/done pulses
module contador_regressivo_seg
    import cronometro_pkg::*;
#(
    parameter bit WRAP = 1'b1
) (
    input  logic       CLK,
    input  logic       P,
    input  logic       TICK,
    input  logic       RUN,
    input  logic       LOAD,
    input  logic [3:0] LOAD_U,
    input  logic [2:0] LOAD_D,
    output logic [6:0] SEG_U,
    output logic [6:0] SEG_D,
    output logic       BORROW,
    output logic       DONE,
    output logic       ZERO
);
    unit_t u, u_nxt;
    tens_t d, d_nxt;
    logic  tick_ok, at_one;
    // LOAD wins over a coincident tick, so the tick is masked here
    assign tick_ok = TICK & RUN & ~LOAD;
    assign ZERO    = (u == '0) && (d == '0);
    assign at_one  = (u == 4'd1) && (d == '0);
    always_comb begin
        u_nxt = u;
        d_nxt = d;
        if (LOAD) begin
            u_nxt = (LOAD_U > UNIT_MAX) ? UNIT_MAX : LOAD_U;
            d_nxt = (LOAD_D > TENS_MAX) ? TENS_MAX : LOAD_D;
        end else if (tick_ok) begin
            if (u != '0)
                u_nxt = u - 4'd1;
            else if ((d != '0) || WRAP) begin
                u_nxt = UNIT_MAX;
                d_nxt = (d != '0) ? d - 3'd1 : TENS_MAX;
            end
        end
    end
    always_ff @(posedge CLK or posedge P) begin
        if (P) begin
            u      <= '0;
            d      <= '0;
            BORROW <= 1'b0;
            DONE   <= 1'b0;
        end else begin
            u      <= u_nxt;
            d      <= d_nxt;
            BORROW <= WRAP && tick_ok && ZERO;
            DONE   <= !WRAP && tick_ok && at_one;
        end
    end
    seg7_dec u_dec_u (.digit(u), .seg(SEG_U));
    seg7_dec u_dec_d (.digit({1'b0, d}), .seg(SEG_D));
endmodule

// File: tb/tb_contador_regressivo_seg.sv
// tb_contador_regressivo_seg: scoreboard bench driving a wrapping and a stopping instance in parallel
module tb_contador_regressivo_seg;
    logic       CLK = 1'b0;
    logic       P = 1'b1;
    logic       TICK = 1'b0;
    logic       RUN = 1'b0;
    logic       LOAD = 1'b0;
    logic [3:0] LOAD_U = '0;
    logic [2:0] LOAD_D = '0;
    logic [6:0] seg_u1, seg_d1, seg_u0, seg_d0;
    logic       borrow1, done1, zero1, borrow0, done0, zero0;

    contador_regressivo_seg #(.WRAP(1'b1)) dut_w (
        .CLK(CLK), .P(P), .TICK(TICK), .RUN(RUN), .LOAD(LOAD), .LOAD_U(LOAD_U), .LOAD_D(LOAD_D),
        .SEG_U(seg_u1), .SEG_D(seg_d1), .BORROW(borrow1), .DONE(done1), .ZERO(zero1));
    contador_regressivo_seg #(.WRAP(1'b0)) dut_s (
        .CLK(CLK), .P(P), .TICK(TICK), .RUN(RUN), .LOAD(LOAD), .LOAD_U(LOAD_U), .LOAD_D(LOAD_D),
        .SEG_U(seg_u0), .SEG_D(seg_d0), .BORROW(borrow0), .DONE(done0), .ZERO(zero0));

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [17:0] w1;
        logic [17:0] w0;
    } exp_t;

    exp_t sb[$];
    logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    int c1 = 0, c0 = 0;
    int n_checks = 0, n_fail = 0;
    int nb1 = 0, nd1 = 0, nb0 = 0, nd0 = 0;

    function automatic logic [17:0] expv(input int c, input bit b, input bit dn);
        return {seg_tab[c % 10], seg_tab[c / 10], c == 0, b, dn};
    endfunction

    // reference behaviour on the combined count 0..59
    function automatic void model(input bit wrap, inout int c, output bit b, output bit dn,
                                  input bit tk, input bit rn, input bit ld, input int lu, input int lt);
        b = 0;
        dn = 0;
        if (ld)
            c = (lu > 9 ? 9 : lu) + 10 * (lt > 5 ? 5 : lt);
        else if (tk && rn) begin
            if (c == 0) begin
                if (wrap) begin
                    c = 59;
                    b = 1;
                end
            end else begin
                c = c - 1;
                dn = !wrap && c == 0;
            end
        end
    endfunction

    task automatic step(input bit tk, input bit rn, input bit ld, input int lu, input int lt);
        bit b, dn;
        exp_t e;
        logic [17:0] o1, o0;
        @(negedge CLK);
        TICK = tk;
        RUN = rn;
        LOAD = ld;
        LOAD_U = 4'(lu);
        LOAD_D = 3'(lt);
        model(1'b1, c1, b, dn, tk, rn, ld, lu, lt);
        e.w1 = expv(c1, b, dn);
        model(1'b0, c0, b, dn, tk, rn, ld, lu, lt);
        e.w0 = expv(c0, b, dn);
        sb.push_back(e);
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        o1 = {seg_u1, seg_d1, zero1, borrow1, done1};
        o0 = {seg_u0, seg_d0, zero0, borrow0, done0};
        nb1 += int'(borrow1);
        nd1 += int'(done1);
        nb0 += int'(borrow0);
        nd0 += int'(done0);
        n_checks += 2;
        if (o1 !== e.w1) begin
            n_fail++;
            $display("FAIL step_wrap t=%0t got=%b want=%b", $time, o1, e.w1);
        end
        if (o0 !== e.w0) begin
            n_fail++;
            $display("FAIL step_stop t=%0t got=%b want=%b", $time, o0, e.w0);
        end
        TICK = 1'b0;
        LOAD = 1'b0;
    endtask

    task automatic chk_reset_state(input string nm);
        n_checks += 2;
        if ({seg_u1, seg_d1, zero1, borrow1, done1} !== {7'b0000001, 7'b0000001, 3'b100}) begin
            n_fail++;
            $display("FAIL %s_wrap got=%b want=%b", nm, {seg_u1, seg_d1, zero1, borrow1, done1},
                     {7'b0000001, 7'b0000001, 3'b100});
        end
        if ({seg_u0, seg_d0, zero0, borrow0, done0} !== {7'b0000001, 7'b0000001, 3'b100}) begin
            n_fail++;
            $display("FAIL %s_stop got=%b want=%b", nm, {seg_u0, seg_d0, zero0, borrow0, done0},
                     {7'b0000001, 7'b0000001, 3'b100});
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk_reset_state("reset_init");
        @(negedge CLK);
        P = 1'b0;
        step(0, 0, 1, 7, 3);
        @(posedge CLK);
        #3;
        P = 1'b1;
        #1;
        chk_reset_state("reset_async");
        @(negedge CLK);
        TICK = 1'b1;
        RUN = 1'b1;
        LOAD = 1'b1;
        LOAD_U = 4'd5;
        @(posedge CLK);
        #1;
        chk_reset_state("reset_ignores_inputs");
        @(negedge CLK);
        P = 1'b0;
        TICK = 1'b0;
        LOAD = 1'b0;
        RUN = 1'b0;
        c1 = 0;
        c0 = 0;
    endtask

    task automatic test_load_tick();
        step(0, 0, 1, 0, 1);
        step(1, 1, 0, 0, 0);
        n_checks++;
        if (seg_u1 !== 7'b0000100 || seg_d1 !== 7'b0000001) begin
            n_fail++;
            $display("FAIL load10_tick got=%b/%b want=0000100/0000001", seg_u1, seg_d1);
        end
        repeat (3) step(1, 0, 0, 0, 0);
    endtask

    task automatic test_wrap();
        step(0, 0, 1, 0, 0);
        nb1 = 0;
        step(1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        repeat (60) step(1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        n_checks++;
        if (nb1 != 2 || nb0 != 0 || nd1 != 0) begin
            n_fail++;
            $display("FAIL wrap_pulses got=%0d/%0d/%0d want=2/0/0", nb1, nb0, nd1);
        end
    endtask

    task automatic test_done();
        nd0 = 0;
        step(0, 0, 1, 2, 0);
        repeat (3) step(1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        n_checks++;
        if (nd0 != 1 || nb0 != 0) begin
            n_fail++;
            $display("FAIL done_pulses got=%0d/%0d want=1/0", nd0, nb0);
        end
    endtask

    task automatic test_clamp();
        step(1, 1, 1, 12, 7);
        n_checks++;
        if (seg_u1 !== 7'b0000100 || seg_d1 !== 7'b0100100) begin
            n_fail++;
            $display("FAIL clamp59 got=%b/%b want=0000100/0100100", seg_u1, seg_d1);
        end
    endtask

    task automatic test_reset_after_wrap();
        step(0, 0, 1, 0, 0);
        step(1, 1, 0, 0, 0);
        #2;
        P = 1'b1;
        #1;
        chk_reset_state("reset_kills_borrow");
        @(negedge CLK);
        P = 1'b0;
        c1 = 0;
        c0 = 0;
        step(1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 80; i++)
            step(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 15), $urandom_range(0, 7));
    endtask

    initial begin
        test_reset();
        test_load_tick();
        test_wrap();
        test_done();
        test_clamp();
        test_reset_after_wrap();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
